// File: rtl/nor3_bist_pkg.sv
// rtl/nor3_bist_pkg.sv - shared constants and truth-table helper for the nor3 BIST sequencer
package nor3_bist_pkg;

   localparam int NUM_VEC = 8;
   localparam int VEC_W   = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   function automatic logic nor3_expect(input logic [VEC_W-1:0] vec);
      return ~|vec;
   endfunction

endpackage

// File: rtl/nor3_bist_vecgen.sv
// rtl/nor3_bist_vecgen.sv - settle, vector and pass counters driving the cell inputs
module nor3_bist_vecgen
   import nor3_bist_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int PASSES = 1
) (
   input  logic             clk,
   input  logic             rn,
   input  logic             load,
   input  logic             en,
   input  logic             clr,
   output logic [VEC_W-1:0] vec,
   output logic             sample_en,
   output logic             last
);

   localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam int PAS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SET_W-1:0] SET_LD   = SET_W'(SETTLE);
   localparam logic [PAS_W-1:0] PAS_LAST = PAS_W'(PASSES - 1);
   localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

   logic [SET_W-1:0] settle;
   logic [PAS_W-1:0] pass_cnt;

   assign sample_en = en && (settle == '0);
   assign last      = sample_en && (vec == VEC_LAST) && (pass_cnt == PAS_LAST);

   // vec wraps 7->0 on the final sample, so the cell inputs return to 000 in FIN
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         vec      <= '0;
         settle   <= '0;
         pass_cnt <= '0;
      end else if (clr) begin
         vec      <= '0;
         settle   <= '0;
         pass_cnt <= '0;
      end else if (load) begin
         vec      <= '0;
         settle   <= SET_LD;
         pass_cnt <= '0;
      end else if (en) begin
         if (settle != '0) begin
            settle <= settle - SET_W'(1);
         end else begin
            vec    <= vec + VEC_W'(1);
            settle <= SET_LD;
            if (last)
               pass_cnt <= '0;
            else if (vec == VEC_LAST)
               pass_cnt <= pass_cnt + PAS_W'(1);
         end
      end
   end

endmodule

// File: rtl/nor3_bist_ctrl.sv
// rtl/nor3_bist_ctrl.sv - BIST sequencer top: FSM, ZN comparator and result registers
module nor3_bist_ctrl
   import nor3_bist_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int PASSES = 1,
   parameter int ERR_W  = 4
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ABORT,
   input  logic             ZN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic             FAIL_VLD,
   output logic [VEC_W-1:0] FAIL_VEC,
   inout  wire              VDD,
   inout  wire              VSS
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic [1:0]       state;
   logic [VEC_W-1:0] vec;
   logic             sample_en;
   logic             last;
   logic             load;
   logic             en;
   logic             clr;
   logic             mismatch;
   logic [ERR_W-1:0] err_nxt;

   assign load = (state == ST_IDLE) && START && !ABORT;
   assign en   = (state == ST_RUN) && !ABORT;
   assign clr  = (state != ST_IDLE) && ABORT;

   nor3_bist_vecgen #(
      .SETTLE (SETTLE),
      .PASSES (PASSES)
   ) u_vecgen (
      .clk       (CLK),
      .rn        (RN),
      .load      (load),
      .en        (en),
      .clr       (clr),
      .vec       (vec),
      .sample_en (sample_en),
      .last      (last)
   );

   assign {A3, A2, A1} = vec;

   // four-state compare so an undriven or X cell output is reported as a failure
   assign mismatch = (ZN !== nor3_expect(vec));

   always_comb begin
      err_nxt = ERR_CNT;
      if (sample_en && mismatch && (ERR_CNT != ERR_MAX))
         err_nxt = ERR_CNT + ERR_W'(1);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= ST_IDLE;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         PASS     <= 1'b0;
         ERR_CNT  <= '0;
         FAIL_VLD <= 1'b0;
         FAIL_VEC <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  state    <= ST_RUN;
                  BUSY     <= 1'b1;
                  PASS     <= 1'b0;
                  ERR_CNT  <= '0;
                  FAIL_VLD <= 1'b0;
                  FAIL_VEC <= '0;
               end
            end
            ST_RUN: begin
               if (ABORT) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                  PASS  <= 1'b0;
               end else if (sample_en) begin
                  ERR_CNT <= err_nxt;
                  if (mismatch && !FAIL_VLD) begin
                     FAIL_VLD <= 1'b1;
                     FAIL_VEC <= vec;
                  end
                  if (last) begin
                     state <= ST_FIN;
                     BUSY  <= 1'b0;
                     DONE  <= 1'b1;
                     PASS  <= (err_nxt == '0);
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               if (ABORT)
                  PASS <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nor3_bist_ctrl.sv
// tb/tb_nor3_bist_ctrl.sv - randomized self-checking bench for nor3_bist_ctrl
module tb_nor3_bist_ctrl;

   logic       CLK = 1'b0;
   logic       rn;
   logic       start [3];
   logic       abort [3];
   logic       zn    [3];
   logic       a1    [3];
   logic       a2    [3];
   logic       a3    [3];
   logic       busy  [3];
   logic       done  [3];
   logic       pass  [3];
   logic       fvld  [3];
   logic [3:0] errc  [3];
   logic [2:0] fvec  [3];
   logic [7:0] tt    [3];
   wire        vdd = 1'b1;
   wire        vss = 1'b0;
   int         total = 0;
   int         bad   = 0;

   always #5 CLK = ~CLK;

   // cell model: truth table indexed by {A3,A2,A1}; 8'h01 is a healthy nor3
   assign zn[0] = tt[0][{a3[0], a2[0], a1[0]}];
   assign zn[1] = tt[1][{a3[1], a2[1], a1[1]}];
   assign zn[2] = tt[2][{a3[2], a2[2], a1[2]}];

   nor3_bist_ctrl #(.SETTLE(2), .PASSES(1), .ERR_W(4)) u0 (
      .CLK(CLK), .RN(rn), .START(start[0]), .ABORT(abort[0]), .ZN(zn[0]),
      .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .BUSY(busy[0]), .DONE(done[0]),
      .PASS(pass[0]), .ERR_CNT(errc[0]), .FAIL_VLD(fvld[0]), .FAIL_VEC(fvec[0]),
      .VDD(vdd), .VSS(vss));

   nor3_bist_ctrl #(.SETTLE(2), .PASSES(3), .ERR_W(4)) u1 (
      .CLK(CLK), .RN(rn), .START(start[1]), .ABORT(abort[1]), .ZN(zn[1]),
      .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .BUSY(busy[1]), .DONE(done[1]),
      .PASS(pass[1]), .ERR_CNT(errc[1]), .FAIL_VLD(fvld[1]), .FAIL_VEC(fvec[1]),
      .VDD(vdd), .VSS(vss));

   nor3_bist_ctrl #(.SETTLE(0), .PASSES(1), .ERR_W(4)) u2 (
      .CLK(CLK), .RN(rn), .START(start[2]), .ABORT(abort[2]), .ZN(zn[2]),
      .A1(a1[2]), .A2(a2[2]), .A3(a3[2]), .BUSY(busy[2]), .DONE(done[2]),
      .PASS(pass[2]), .ERR_CNT(errc[2]), .FAIL_VLD(fvld[2]), .FAIL_VEC(fvec[2]),
      .VDD(vdd), .VSS(vss));

   function automatic int set_of(input int i);
      return (i == 2) ? 0 : 2;
   endfunction

   function automatic int pas_of(input int i);
      return (i == 1) ? 3 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // results after the first n samples of a sweep over vectors 0..7 repeated
   function automatic void model(input logic [7:0] t, input int n,
                                 output int cnt, output int fv, output bit fl);
      cnt = 0;
      fv  = 0;
      fl  = 1'b0;
      for (int j = 0; j < n; j++) begin
         int v;
         v = j % 8;
         if (t[v] != (v == 0)) begin
            cnt++;
            if (!fl) begin
               fl = 1'b1;
               fv = v;
            end
         end
      end
      if (cnt > 15) cnt = 15;
   endfunction

   task automatic expect_all(input int i, input string tag, input int b, input int a,
                             input int d, input int p, input int e, input int fl, input int fv);
      chk({tag, ".busy"}, 32'(busy[i]), b);
      chk({tag, ".a"},    32'({a3[i], a2[i], a1[i]}), a);
      chk({tag, ".done"}, 32'(done[i]), d);
      chk({tag, ".pass"}, 32'(pass[i]), p);
      chk({tag, ".err"},  32'(errc[i]), e);
      chk({tag, ".fvld"}, 32'(fvld[i]), fl);
      chk({tag, ".fvec"}, 32'(fvec[i]), fv);
   endtask

   task automatic run(input int i, input logic [7:0] t, input int abort_k, input bit hold);
      int    s, p, tot, n, cnt, fv;
      bit    fl;
      string tg;
      s   = set_of(i);
      p   = pas_of(i);
      tot = 8 * p * (s + 1);
      tt[i] = t;
      @(negedge CLK);
      start[i] = 1'b1;
      @(posedge CLK);
      #1;
      if (!hold) start[i] = 1'b0;
      for (int k = 0; k <= tot + 2; k++) begin
         @(negedge CLK);
         tg = $sformatf("d%0d.k%0d", i, k);
         if (abort_k >= 0 && k > abort_k) begin
            model(t, abort_k / (s + 1), cnt, fv, fl);
            expect_all(i, {tg, ".abort"}, 0, 0, 0, 0, cnt, int'(fl), fv);
            abort[i] = 1'b0;
            if (k == abort_k + 2) break;
         end else if (hold && k == tot + 2) begin
            expect_all(i, {tg, ".restart"}, 1, 0, 0, 0, 0, 0, 0);
            start[i] = 1'b0;
            abort[i] = 1'b1;
            @(negedge CLK);
            abort[i] = 1'b0;
            chk({tg, ".cleanup.busy"}, 32'(busy[i]), 0);
         end else begin
            n = (k / (s + 1) < 8 * p) ? k / (s + 1) : 8 * p;
            model(t, n, cnt, fv, fl);
            expect_all(i, tg, int'(k < tot), (k < tot) ? (k / (s + 1)) % 8 : 0,
                       int'(k == tot), int'(k >= tot && cnt == 0), cnt, int'(fl), fv);
            if (k == abort_k) abort[i] = 1'b1;
         end
      end
   endtask

   initial begin
      rn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0;
         abort[i] = 1'b0;
         tt[i]    = 8'h01;
      end
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 3; i++)
         expect_all(i, $sformatf("reset.d%0d", i), 0, 0, 0, 0, 0, 0, 0);
      rn = 1'b1;

      run(0, 8'h01, -1, 1'b0);
      run(0, 8'h00, -1, 1'b0);
      run(1, 8'hff, -1, 1'b0);

      // abort while vector 4 is held, with a random faulty cell, then a clean rerun
      run(0, 8'($urandom), 12 + int'($urandom_range(0, 2)), 1'b0);
      run(0, 8'h01, -1, 1'b0);

      tt[0] = 8'h00;
      @(negedge CLK);
      start[0] = 1'b1;
      @(posedge CLK);
      #1;
      start[0] = 1'b0;
      repeat (6) @(negedge CLK);
      chk("midrun.err", 32'(errc[0]), 1);
      chk("midrun.busy", 32'(busy[0]), 1);
      #2;
      rn = 1'b0;
      #1;
      expect_all(0, "async_rst", 0, 0, 0, 0, 0, 0, 0);
      #1;
      rn = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         expect_all(0, "post_rst", 0, 0, 0, 0, 0, 0, 0);
      end

      run(2, 8'h01, -1, 1'b1);

      repeat (8) begin
         int i, ab;
         i  = int'($urandom_range(0, 2));
         ab = ($urandom_range(0, 2) == 0)
              ? int'($urandom_range(0, 8 * pas_of(i) * (set_of(i) + 1) - 1)) : -1;
         run(i, 8'($urandom), ab, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
